// File: rtl/datapath_pkg.sv
// Shared definitions for the single-cycle datapath.
// Holds the default operand/index widths, the architectural register
// indices with special meaning, and the bit positions of the ALU flags
// so that the ALU, the register bank and the branch logic agree on them.
package datapath_pkg;

  // Default operand width and register index width (16 registers).
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  // Register 0 is hardwired to zero, register 1 is the stack pointer.
  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 1;

  // Flag vector ordering {carry, zero, sign}, shared with the ALU.
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_SIGN  = 0;
  localparam int FLAG_W     = 3;

endpackage : datapath_pkg

// File: rtl/flags_register.sv
// Flags latch for the ALU condition codes.
// A small enable register with asynchronous active-low clear that holds the
// {carry, zero, sign} vector for the downstream branch logic.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low clear (q goes to 0)
//   en    - capture strobe; when low q holds
//   d     - incoming flags from the ALU
//   q     - latched flags
module flags_register
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [FLAG_W-1:0] d,
  output logic [FLAG_W-1:0] q
);

  // Capture the ALU flags only when strobed; reset clears every flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : flags_register

// File: rtl/reg_bank_flags.sv
// Architectural register bank plus flags register for the single-cycle
// datapath. Two combinational read ports feed the ALU operands, one
// synchronous write port captures the ALU result (or load data), and a
// separate flags latch captures the ALU condition codes.
// Ports:
//   clk, rst_n         - clock and asynchronous active-low reset
//   rs_addr / rs_data  - read port A (ALU input A)
//   rt_addr / rt_data  - read port B (ALU input B)
//   wr_en, wr_addr,
//   wr_data            - write port; writes to register 0 are dropped
//   flags_we, flags_in - flags capture strobe and ALU flags {carry,zero,sign}
//   flags_out          - latched flags
module reg_bank_flags #(
  parameter int                 DATA_W  = datapath_pkg::DATA_W,
  parameter int                 ADDR_W  = datapath_pkg::ADDR_W,
  parameter logic [DATA_W-1:0]  SP_INIT = 32'h0000_03FC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flags_we,
  input  logic [2:0]        flags_in,
  output logic [2:0]        flags_out
);

  import datapath_pkg::*;

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Register array. Entry 0 is never written so it stays at its reset
  // value; the read muxes also force it to zero so it reads as a constant.
  // The write is gated by wr_en first so an undefined wr_addr while idle
  // cannot reach any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == REG_SP) ? SP_INIT : '0;
      end
    end else if (wr_en && (wr_addr != ZERO_IDX)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports come straight from the stored array with no write bypass;
  // a bypass would close a loop through the ALU back onto wr_data.
  assign rs_data = (rs_addr == ZERO_IDX) ? '0 : regs[rs_addr];
  assign rt_data = (rt_addr == ZERO_IDX) ? '0 : regs[rt_addr];

  flags_register u_flags (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flags_we),
    .d     (flags_in),
    .q     (flags_out)
  );

endmodule : reg_bank_flags

// File: tb/tb_reg_bank_flags.sv
// Self-checking bench for reg_bank_flags.
// The stimulus process drives one operation per clock, predicts the read
// port and flag values from a plain array model of the architectural
// state, and queues that prediction. A separate monitor samples the DUT on
// each falling edge, pops the oldest prediction and compares.
module tb_reg_bank_flags;

  typedef struct {
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic [2:0]  exp_flags;
    string       name;
  } expect_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rs_addr;
  logic [3:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        flags_we;
  logic [2:0]  flags_in;
  logic [2:0]  flags_out;

  expect_t     exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  // Reference state: sixteen architectural registers and the flag vector.
  logic [31:0] model_regs [16];
  logic [2:0]  model_flags;

  reg_bank_flags dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .flags_we  (flags_we),
    .flags_in  (flags_in),
    .flags_out (flags_out)
  );

  // 10 time-unit clock; inputs change 1 unit after the rising edge and the
  // monitor samples on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void modelReset();
    for (int i = 0; i < 16; i++) model_regs[i] = 32'h0;
    model_regs[1] = 32'h0000_03FC;
    model_flags = 3'b000;
  endfunction

  function automatic logic [31:0] modelRead(input logic [3:0] a);
    return (a == 4'd0) ? 32'h0 : model_regs[a];
  endfunction

  task automatic checkOutput(input string name, input string what,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s %s actual=%h expected=%h", name, what, actual, expected);
    end
  endtask

  // One clock of stimulus. Called 1 unit after a rising edge; predicts the
  // pre-edge read values, then commits the operation to the model at the
  // next rising edge (unless reset is being held).
  task automatic applyStimulus(input bit hold_reset,
                               input logic [3:0] rs, input logic [3:0] rt,
                               input logic we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic fwe, input logic [2:0] fin,
                               input string name);
    expect_t e;
    rst_n    = !hold_reset;
    rs_addr  = rs;
    rt_addr  = rt;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    flags_we = fwe;
    flags_in = fin;
    e.exp_rs    = modelRead(rs);
    e.exp_rt    = modelRead(rt);
    e.exp_flags = model_flags;
    e.name      = name;
    exp_q.push_back(e);
    @(posedge clk);
    if (!hold_reset) begin
      if (we && wa != 4'd0) model_regs[wa] = wd;
      if (fwe) model_flags = fin;
    end
    #1;
  endtask

  // Drop reset between clock edges and release it before the next edge;
  // the falling-edge sample lands inside the low pulse.
  task automatic pulseReset(input logic [3:0] rs, input logic [3:0] rt, input string name);
    expect_t e;
    wr_en    = 1'b0;
    flags_we = 1'b0;
    rs_addr  = rs;
    rt_addr  = rt;
    rst_n    = 1'b0;
    modelReset();
    e.exp_rs    = modelRead(rs);
    e.exp_rt    = modelRead(rt);
    e.exp_flags = model_flags;
    e.name      = name;
    exp_q.push_back(e);
    #6;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every falling edge with a pending prediction is compared.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e.name, "rs_data", rs_data, e.exp_rs);
        checkOutput(e.name, "rt_data", rt_data, e.exp_rt);
        checkOutput(e.name, "flags_out", {29'h0, flags_out}, {29'h0, e.exp_flags});
      end
    end
  end

  initial begin
    logic [3:0]  r_rs, r_rt, r_wa;
    logic [31:0] r_wd;
    logic        r_we, r_fwe;
    logic [2:0]  r_fin;
    int          budget;

    rst_n    = 1'b0;
    rs_addr  = 4'd1;
    rt_addr  = 4'd5;
    wr_en    = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 32'h0;
    flags_we = 1'b0;
    flags_in = 3'b000;
    modelReset();

    @(posedge clk);
    #1;
    // Reset held: reset contents visible, a write attempt must be ignored.
    applyStimulus(1'b1, 4'd1, 4'd5, 1'b0, 4'd0, 32'h0, 1'b0, 3'b000, "reset_values");
    applyStimulus(1'b1, 4'd1, 4'd2, 1'b1, 4'd2, 32'hAAAA_5555, 1'b1, 3'b111, "reset_blocks_write");

    // Directed sequence.
    applyStimulus(1'b0, 4'd1, 4'd7, 1'b1, 4'd7, 32'hDEAD_BEEF, 1'b0, 3'b000, "write_r7");
    applyStimulus(1'b0, 4'd7, 4'd7, 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b0, 3'b000, "read_r7_write_r0");
    applyStimulus(1'b0, 4'd0, 4'd7, 1'b1, 4'd3, 32'h0000_0011, 1'b0, 3'b000, "r0_reads_zero");
    applyStimulus(1'b0, 4'd3, 4'd0, 1'b1, 4'd3, 32'h0000_0022, 1'b1, 3'b110, "read_during_write");
    applyStimulus(1'b0, 4'd3, 4'd1, 1'b0, 4'd0, 32'h0, 1'b0, 3'b001, "after_write_flags_set");
    applyStimulus(1'b0, 4'd3, 4'd7, 1'b1, 4'd1, 32'h0000_0055, 1'b1, 3'b111, "flags_hold");
    wr_addr = 4'bxxxx;
    applyStimulus(1'b0, 4'd1, 4'd3, 1'b0, 4'bxxxx, 32'h1234_5678, 1'b0, 3'b000, "r1_written_x_addr_idle");
    pulseReset(4'd1, 4'd7, "async_reset_pulse");
    applyStimulus(1'b0, 4'd1, 4'd3, 1'b0, 4'd0, 32'h0, 1'b0, 3'b000, "after_reset_release");

    // Randomized traffic, including writes to r0 and simultaneous strobes.
    for (int n = 0; n < 300; n++) begin
      r_rs  = 4'($urandom_range(0, 15));
      r_rt  = ($urandom_range(0, 3) == 0) ? r_rs : 4'($urandom_range(0, 15));
      r_we  = 1'($urandom_range(0, 1));
      r_wa  = 4'($urandom_range(0, 15));
      r_wd  = $urandom;
      r_fwe = 1'($urandom_range(0, 1));
      r_fin = 3'($urandom_range(0, 7));
      applyStimulus(1'b0, r_rs, r_rt, r_we, r_wa, r_wd, r_fwe, r_fin, "random");
    end
    pulseReset(4'd1, 4'($urandom_range(2, 15)), "random_reset_pulse");
    applyStimulus(1'b0, 4'd1, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 3'b000, "final_idle");

    // Let the monitor drain, bounded by a cycle budget.
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_bank_flags
